regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the 5-stage pipeline; successor to the fixed 32x32, 2-read/1-write regfile.
- Adds configurable width, depth and read-port count, a second write port, optional write-to-read bypass, optional hardwired-zero r0, async reset clearing, and a per-register pending scoreboard for decode-stage hazard checks.
- Sits between decode (reads, issue-marking) and writeback (two write ports: ALU/load and a late-completing unit).

---
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with two
// write ports, optional write bypass, hardwired r0 and pending scoreboard.
module regfile_mp #(
  parameter int DW      = 32,
  parameter int DEPTH   = 32,
  parameter int AW      = $clog2(DEPTH),
  parameter int NR      = 2,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  output logic [NR-1:0]    rbusy,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [DW-1:0]    wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [DW-1:0]    wdata1,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  output logic [AW:0]      busy_cnt
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nx;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_nx;
  logic             keep0;
  logic             keep1;

  assign keep0 = we0 && !(ZERO_R0 && waddr0 == '0);
  assign keep1 = we1 && !(ZERO_R0 && waddr1 == '0);

  // set is applied last so a new producer supersedes a same-cycle clear
  always_comb begin
    pend_nx = pend;
    if (we0) pend_nx[waddr0] = 1'b0;
    if (we1) pend_nx[waddr1] = 1'b0;
    if (set_en) pend_nx[set_addr] = 1'b1;
    if (ZERO_R0) pend_nx[0] = 1'b0;
  end

  always_comb begin
    cnt_nx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nx = cnt_nx + (AW+1)'(pend_nx[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_nx;
      cnt  <= cnt_nx;
    end
  end

  // port 1 is written last so it wins an address conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (keep0) mem[waddr0] <= wdata0;
      if (keep1) mem[waddr1] <= wdata1;
    end
  end

  assign busy_cnt = cnt;

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          rb;
    logic          hit0;
    logic          hit1;

    assign ra   = raddr[i*AW +: AW];
    assign hit0 = BYPASS && !rst && we0 && waddr0 == ra;
    assign hit1 = BYPASS && !rst && we1 && waddr1 == ra;

    always_comb begin
      rd = mem[ra];
      rb = pend[ra];
      if (hit0 || hit1) rb = 1'b0;
      if (hit1) rd = wdata1;
      else if (hit0) rd = wdata0;
      if (ZERO_R0 && ra == '0) rd = '0;
    end

    assign rdata[i*DW +: DW] = rd;
    assign rbusy[i]          = rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for two regfile_mp builds
// (bypass+zero-r0, and plain) driven by shared stimulus.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  typedef struct {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rb;
    logic [AW:0]      cnt;
  } exp_t;

  logic clk = 0;
  logic rst;
  logic [NR*AW-1:0] raddr;
  logic we0, we1, set_en;
  logic [AW-1:0] waddr0, waddr1, set_addr;
  logic [DW-1:0] wdata0, wdata1;
  logic [NR*DW-1:0] rdata_a, rdata_b;
  logic [NR-1:0] rbusy_a, rbusy_b;
  logic [AW:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NR(NR),
    .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_a (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a),
    .rbusy(rbusy_a), .we0(we0), .waddr0(waddr0),
    .wdata0(wdata0), .we1(we1), .waddr1(waddr1),
    .wdata1(wdata1), .set_en(set_en), .set_addr(set_addr),
    .busy_cnt(cnt_a));

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NR(NR),
    .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b),
    .rbusy(rbusy_b), .we0(we0), .waddr0(waddr0),
    .wdata0(wdata0), .we1(we1), .waddr1(waddr1),
    .wdata1(wdata1), .set_en(set_en), .set_addr(set_addr),
    .busy_cnt(cnt_b));

  // reference state: [0] models dut_a, [1] models dut_b
  int unsigned m_mem [2][DEPTH];
  bit          m_pnd [2][DEPTH];
  bit          m_byp [2] = '{1'b1, 1'b0};
  bit          m_zr  [2] = '{1'b1, 1'b0};

  exp_t q_a[$];
  exp_t q_b[$];
  int vectors = 0;
  int miscompares = 0;
  bit done = 0;

  // staged stimulus
  bit s_rst, s_we0, s_we1, s_set;
  int s_wa0, s_wa1, s_sa, s_ra0, s_ra1;
  int unsigned s_wd0, s_wd1;

  task automatic idle();
    s_rst = 0; s_we0 = 0; s_we1 = 0; s_set = 0;
    s_wa0 = 0; s_wa1 = 0; s_sa = 0; s_wd0 = 0; s_wd1 = 0;
  endtask

  function automatic exp_t expect_of(int k, int ra0, int ra1);
    exp_t e;
    int a;
    int c;
    e.rd = '0;
    e.rb = '0;
    e.cnt = '0;
    if (s_rst) return e;
    for (int p = 0; p < NR; p++) begin
      int unsigned v;
      bit b;
      a = (p == 0) ? ra0 : ra1;
      v = m_mem[k][a];
      b = m_pnd[k][a];
      if (m_byp[k] && s_we0 && s_wa0 == a) begin
        v = s_wd0; b = 0;
      end
      if (m_byp[k] && s_we1 && s_wa1 == a) begin
        v = s_wd1; b = 0;
      end
      if (m_zr[k] && a == 0) v = 0;
      e.rd[p*DW +: DW] = v;
      e.rb[p] = b;
    end
    c = 0;
    for (int r = 0; r < DEPTH; r++) c += m_pnd[k][r];
    e.cnt = c[AW:0];
    return e;
  endfunction

  function automatic void advance(int k);
    if (s_rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[k][r] = 0; m_pnd[k][r] = 0;
      end
      return;
    end
    if (s_we0 && !(m_zr[k] && s_wa0 == 0)) m_mem[k][s_wa0] = s_wd0;
    if (s_we1 && !(m_zr[k] && s_wa1 == 0)) m_mem[k][s_wa1] = s_wd1;
    if (s_we0) m_pnd[k][s_wa0] = 0;
    if (s_we1) m_pnd[k][s_wa1] = 0;
    if (s_set && !(m_zr[k] && s_sa == 0)) m_pnd[k][s_sa] = 1;
  endfunction

  task automatic step(input int ra0, input int ra1);
    @(negedge clk);
    #1;
    rst = s_rst; we0 = s_we0; we1 = s_we1; set_en = s_set;
    waddr0 = s_wa0[AW-1:0]; waddr1 = s_wa1[AW-1:0];
    set_addr = s_sa[AW-1:0];
    wdata0 = s_wd0; wdata1 = s_wd1;
    raddr = {ra1[AW-1:0], ra0[AW-1:0]};
    q_a.push_back(expect_of(0, ra0, ra1));
    q_b.push_back(expect_of(1, ra0, ra1));
    advance(0);
    advance(1);
  endtask

  task automatic cmp(input string n, input logic [63:0] act,
                     input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, act, want);
    end
  endtask

  // monitor: pops one expectation per instance each cycle
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #3;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        cmp("a.rdata", 64'(rdata_a), 64'(e.rd));
        cmp("a.rbusy", 64'(rbusy_a), 64'(e.rb));
        cmp("a.busy_cnt", 64'(cnt_a), 64'(e.cnt));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        cmp("b.rdata", 64'(rdata_b), 64'(e.rd));
        cmp("b.rbusy", 64'(rbusy_b), 64'(e.rb));
        cmp("b.busy_cnt", 64'(cnt_b), 64'(e.cnt));
      end
    end
  end

  initial begin
    rst = 1; we0 = 0; we1 = 0; set_en = 0;
    waddr0 = 0; waddr1 = 0; set_addr = 0;
    wdata0 = 0; wdata1 = 0; raddr = 0;
    idle();
    s_rst = 1; step(5, 0); step(5, 0);
    idle();
    // async reset wipes r5 immediately
    s_we0 = 1; s_wa0 = 5; s_wd0 = 32'hDEADBEEF; step(5, 0);
    idle(); step(5, 5);
    s_rst = 1; step(5, 5);
    idle(); step(5, 0);
    // bypass on port 0 write
    s_we0 = 1; s_wa0 = 7; s_wd0 = 32'h12345678; step(7, 1);
    idle(); step(7, 7);
    // writes to r0
    s_we0 = 1; s_wa0 = 0; s_wd0 = 32'hFFFFFFFF; step(3, 0);
    idle(); step(0, 0);
    // dual-write conflict
    s_we0 = 1; s_wa0 = 3; s_wd0 = 32'h11;
    s_we1 = 1; s_wa1 = 3; s_wd1 = 32'h22; step(3, 2);
    idle(); step(2, 3);
    // scoreboard set then clear
    s_set = 1; s_sa = 9; step(9, 0);
    idle(); step(9, 1);
    s_we1 = 1; s_wa1 = 9; s_wd1 = 32'hA5; step(1, 9);
    idle(); step(9, 9);
    // set/clear collision
    s_set = 1; s_sa = 4; step(4, 0);
    s_set = 1; s_sa = 4; s_we0 = 1; s_wa0 = 4; s_wd0 = 32'h44;
    step(4, 4);
    idle(); step(4, 0);
    s_we0 = 1; s_wa0 = 4; s_wd0 = 32'h45; step(4, 0);
    idle();
    // fill all pending
    for (int r = 1; r < DEPTH; r++) begin
      s_set = 1; s_sa = r; step(r, r - 1);
    end
    idle(); step(31, 1);
    s_set = 1; s_sa = 0; step(0, 1);
    idle(); step(0, 30);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      s_rst = ($urandom_range(0, 60) == 0);
      s_we0 = $urandom_range(0, 1);
      s_we1 = ($urandom_range(0, 2) == 0);
      s_set = $urandom_range(0, 1);
      s_wa0 = $urandom_range(0, DEPTH - 1);
      s_wa1 = ($urandom_range(0, 3) == 0) ? s_wa0
            : $urandom_range(0, DEPTH - 1);
      s_sa = ($urandom_range(0, 4) == 0) ? s_wa0
           : $urandom_range(0, DEPTH - 1);
      s_wd0 = $urandom;
      s_wd1 = $urandom;
      step(($urandom_range(0, 2) == 0) ? s_wa0
           : $urandom_range(0, DEPTH - 1),
           ($urandom_range(0, 2) == 0) ? s_wa1
           : $urandom_range(0, DEPTH - 1));
    end
    idle();
    step(0, 0);
    for (int w = 0; w < 4 && (q_a.size() + q_b.size()) > 0; w++) begin
      @(negedge clk);
    end
    @(negedge clk);
    #4;
    done = 1;
    cmp("queue_drain", 64'(q_a.size() + q_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
